// File: rtl/periferico_tx.sv
// Peripheral-side initiator of the 4-bit send/ack four-phase handshake.
// Local writes land in a small FIFO; each word is then presented on dados
// for one setup cycle, send is raised, and the block waits for the CPU to
// raise and then drop ack (seen only through a 2-flop synchroniser).
// A word that is not acked within TIMEOUT cycles is dropped and erro is set.
module periferico_tx #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [3:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic [3:0] dados,
   output logic       send,
   input  logic       ack,
   output logic [1:0] estado,
   output logic       erro,
   input  logic       erro_clr,
   output logic [7:0] tx_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);
   localparam logic [AW:0]   CFULL = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      LOAD    = 2'b01,
      SEND    = 2'b10,
      RELEASE = 2'b11
   } state_t;

   state_t          state_q, state_d;
   logic            ack_meta_q, ack_s_q;
   logic [3:0]      mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic            full_q, empty_q;
   logic [3:0]      dados_q, dados_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic            erro_q, erro_d;
   logic [7:0]      tx_q, tx_d;
   logic            pop, push;

   // The FSM pops only from IDLE; a write to a full FIFO is still taken
   // when a pop frees the head slot in the same cycle.
   assign pop  = (state_q == IDLE) && !empty_q;
   assign push = wr_en && (!full_q || pop);

   // Two-flop synchroniser for the CPU-domain ack.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_meta_q <= 1'b0;
         ack_s_q    <= 1'b0;
      end else begin
         ack_meta_q <= ack;
         ack_s_q    <= ack_meta_q;
      end
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
         2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage, pointers and registered full/empty flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push) mem_q[wptr_q] <= wr_data;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == CFULL);
         empty_q <= (cnt_d == '0);
      end
   end

   // Handshake FSM: next state, timeout counter, data latch, error and count.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      dados_d = dados_q;
      erro_d  = erro_q;
      tx_d    = tx_q;
      if (erro_clr) erro_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            tmr_d = '0;
            if (!empty_q) begin
               dados_d = mem_q[rptr_q];
               state_d = LOAD;
            end
         end
         LOAD: state_d = SEND;
         SEND: begin
            if (ack_s_q) begin
               tx_d    = tx_q + 8'd1;
               state_d = RELEASE;
            end else if (tmr_q == TMAX) begin
               // Timeout set overrides a same-cycle clear.
               erro_d  = 1'b1;
               state_d = RELEASE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         RELEASE: begin
            if (!ack_s_q) begin
               tmr_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         dados_q <= '0;
         erro_q  <= 1'b0;
         tx_q    <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         dados_q <= dados_d;
         erro_q  <= erro_d;
         tx_q    <= tx_d;
      end
   end

   // send is a pure state decode so reset drops it immediately.
   assign send     = (state_q == SEND);
   assign estado   = state_q;
   assign dados    = dados_q;
   assign erro     = erro_q;
   assign tx_count = tx_q;
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: tb/tb_periferico_tx.sv
// Bench for periferico_tx: a CPU ack responder and a word monitor run
// alongside a linear sequence of directed and randomized steps. Expected
// words sit in a queue in write order; expected send pulse length is set
// from the responder's ack delay (or TIMEOUT when it stays silent).
module tb_periferico_tx;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, ack = 1'b0, erro_clr = 1'b0;
   logic [3:0] wr_data = '0;
   logic       full, empty, send, erro;
   logic [3:0] dados;
   logic [1:0] estado;
   logic [7:0] tx_count;

   int         checks = 0, failures = 0;
   logic [3:0] exp_q [$];
   int         tx_m = 0;
   bit         ack_en = 1'b0;
   int         ack_dly = 0, rel_dly = 0, exp_len = 0;
   bit         in_pulse = 1'b0;
   int         plen = 0;
   int         total = 0, nb = 0;
   logic [3:0] d;

   always #5 clk = ~clk;

   periferico_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .dados(dados), .send(send), .ack(ack),
      .estado(estado), .erro(erro), .erro_clr(erro_clr), .tx_count(tx_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; holds wr_en across exactly one rising edge.
   task automatic wr(input logic [3:0] w);
      wr_en = 1'b1; wr_data = w;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_st(input string tag, input logic [1:0] st);
      int n = 0;
      while (estado !== st && n < 300) begin @(negedge clk); n++; end
      chk(tag, n < 300, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (!(estado == 2'd0 && empty && !send && !ack) && n < 300) begin
         @(negedge clk); n++;
      end
      chk(tag, n < 300, 1);
   endtask

   initial begin
      fork
         // Monitor: word on the bus at LOAD and at send rise, pulse length at fall.
         forever begin
            @(negedge clk);
            if (!rst) in_pulse = 1'b0;
            else begin
               if (estado == 2'd1) begin
                  chk("load_qsize", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) chk("load_dados", dados, exp_q[0]);
               end
               if (send && !in_pulse) begin
                  chk("send_qsize", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) chk("send_dados", dados, exp_q.pop_front());
                  in_pulse = 1'b1; plen = 1;
               end else if (send) plen++;
               else if (in_pulse) begin
                  chk("send_len", plen, exp_len);
                  in_pulse = 1'b0;
               end
            end
         end
         // CPU responder: ack after ack_dly cycles, drop rel_dly cycles after send falls.
         forever begin
            @(negedge clk);
            if (rst && ack_en && send && !ack) begin
               repeat (ack_dly) @(negedge clk);
               ack = 1'b1;
               while (send) @(negedge clk);
               repeat (rel_dly) @(negedge clk);
               ack = 1'b0;
            end
         end
      join_none

      // Reset
      #1 rst = 1'b0;
      #10;
      chk("rst_estado", estado, 0); chk("rst_send", send, 0);
      chk("rst_dados", dados, 0);   chk("rst_erro", erro, 0);
      chk("rst_tx", tx_count, 0);   chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      @(negedge clk); rst = 1'b1;

      // 1: single word, slow ack
      ack_en = 1'b1; ack_dly = 4; rel_dly = 4; exp_len = 7;
      exp_q.push_back(4'hA); wr(4'hA); tx_m++;
      wait_idle("t1_idle");
      chk("t1_tx", tx_count, tx_m % 256); chk("t1_estado", estado, 0);
      chk("t1_empty", empty, 1); chk("t1_dados_hold", dados, 4'hA);

      // 2: fill while the first word is in flight; one extra write dropped
      ack_dly = 4; rel_dly = 2; exp_len = 7;
      for (int i = 1; i <= 5; i++) begin
         d = 4'(i); exp_q.push_back(d); wr(d);
      end
      chk("t2_full", full, 1);
      wr(4'h6);
      chk("t2_full_drop", full, 1);
      tx_m += 5;
      wait_idle("t2_idle");
      chk("t2_tx", tx_count, tx_m % 256); chk("t2_empty", empty, 1);

      // 3: FIFO full in IDLE, write on the pop cycle is accepted
      ack_dly = 1; rel_dly = 12; exp_len = 4;
      d = 4'($urandom_range(0, 15)); exp_q.push_back(d); wr(d);
      wait_st("t3_rel", 2'd3);
      for (int i = 0; i < 4; i++) begin
         d = 4'($urandom_range(0, 15)); exp_q.push_back(d); wr(d);
      end
      chk("t3_full", full, 1); chk("t3_in_rel", estado, 3);
      wait_st("t3_idle", 2'd0);
      exp_q.push_back(4'h7); wr(4'h7);
      chk("t3_full_kept", full, 1); chk("t3_load", estado, 1);
      tx_m += 6;
      wait_idle("t3_done");
      chk("t3_tx", tx_count, tx_m % 256);

      // 4: timeout, clear, set-wins, then a normal word
      ack_en = 1'b0; exp_len = TIMEOUT;
      exp_q.push_back(4'h9); wr(4'h9);
      wait_idle("t4_idle");
      chk("t4_erro", erro, 1); chk("t4_tx", tx_count, tx_m % 256);
      erro_clr = 1'b1; @(negedge clk); erro_clr = 1'b0;
      chk("t4_erro_clr", erro, 0);
      exp_q.push_back(4'hC); wr(4'hC);
      repeat (9) @(negedge clk);
      chk("t4_send_last", send, 1);
      erro_clr = 1'b1; @(negedge clk); erro_clr = 1'b0;
      chk("t4_set_wins", erro, 1); chk("t4_send_off", send, 0);
      wait_idle("t4_idle2");
      erro_clr = 1'b1; @(negedge clk); erro_clr = 1'b0;
      chk("t4_erro_clr2", erro, 0);
      ack_en = 1'b1; ack_dly = 2; rel_dly = 1; exp_len = 5;
      exp_q.push_back(4'h2); wr(4'h2); tx_m++;
      wait_idle("t4_next");
      chk("t4_tx_next", tx_count, tx_m % 256); chk("t4_erro_next", erro, 0);

      // Spurious ack in IDLE, still high at SEND entry -> one-cycle send
      ack_en = 1'b0; ack = 1'b1;
      repeat (6) @(negedge clk);
      chk("sp_estado", estado, 0); chk("sp_tx", tx_count, tx_m % 256);
      exp_len = 1;
      exp_q.push_back(4'h3); wr(4'h3);
      wait_st("sp_rel", 2'd3);
      ack = 1'b0; tx_m++;
      wait_idle("sp_idle");
      chk("sp_tx_done", tx_count, tx_m % 256);

      // 5: reset mid-SEND with ack high
      exp_q.push_back(4'hD); wr(4'hD);
      wait_st("rs_send", 2'd2);
      ack = 1'b1;
      @(posedge clk); #2 rst = 1'b0; #1;
      chk("rs_send_low", send, 0); chk("rs_estado", estado, 0);
      chk("rs_dados", dados, 0);   chk("rs_empty", empty, 1);
      chk("rs_tx", tx_count, 0);   chk("rs_full", full, 0);
      exp_q.delete(); tx_m = 0; ack = 1'b0;
      @(negedge clk); rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("rs_quiet_estado", estado, 0); chk("rs_quiet_tx", tx_count, 0);
      chk("rs_quiet_empty", empty, 1);

      // 6: randomized bursts until tx_count wraps
      while (total < 260) begin
         nb = $urandom_range(1, 5);
         ack_en = 1'b1; ack_dly = $urandom_range(0, 4); rel_dly = $urandom_range(0, 3);
         exp_len = ack_dly + 3;
         for (int i = 0; i < nb; i++) begin
            d = 4'($urandom_range(0, 15)); exp_q.push_back(d); wr(d);
         end
         total += nb; tx_m += nb;
         wait_idle("t6_idle");
         chk("t6_tx", tx_count, tx_m % 256); chk("t6_erro", erro, 0);
      end
      chk("final_q", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
